writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  writeback request present.
- ready_o  out  1  unit accepts a request this cycle.
- wb_en_i  in  1  request writes a register.
- dest_i  in  5  destination register number.
- result_i  in  32  ALU result, used when is_load_i=0.
- is_load_i  in  1  request is a load; data comes from memory.
- load_type_i  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes act as LW.
- addr_lo_i  in  2  load byte address bits [1:0].
- flush_i  in  1  abandon an outstanding load.
- mem_valid_i  in  1  mem_data_i valid this cycle.
- mem_data_i  in  32  load word; byte k is bits [8k+7:8k] (little-endian lanes).
- rf_we_o  out  1  register-file write enable.
- rf_wr_addr_o  out  5  register-file write address.
- rf_wr_data_o  out  32  register-file write data.
- pending_o  out  1  load is outstanding.
- pending_dest_o  out  5  destination of the outstanding load.
- misalign_o  out  1  one-cycle pulse for a dropped misaligned load.

Function
REQ-002 SHALL implement the FSM states IDLE, WAIT_MEM and WRITE.
REQ-003 SHALL drive ready_o=1 in IDLE and WRITE and ready_o=0 in WAIT_MEM; a request is accepted when valid_i && ready_o && !flush_i.
REQ-004 SHALL handle an accepted non-load as follows: latch result_i into the write register and go to WRITE next cycle.
REQ-005 SHALL handle an accepted load as follows: latch dest, load_type and addr_lo, then go to WAIT_MEM.
REQ-006 SHALL, in WAIT_MEM with mem_valid_i=1, extract and extend the data, latch it and go to WRITE.
- LH/LB: sign-extend; LHU/LBU: zero-extend.
- Halfword select uses addr_lo[1]; byte select uses addr_lo.
REQ-007 SHALL, in WAIT_MEM, drive pending_o=1 and pending_dest_o=latched dest; otherwise both outputs are 0.
REQ-008 SHALL, in WRITE, drive rf_we_o=1 for exactly one cycle if wb_en was set and dest!=0; rf_wr_addr_o and rf_wr_data_o are valid in that cycle.
REQ-009 SHALL never assert rf_we_o for dest=0.
REQ-010 SHALL hold rf_wr_addr_o and rf_wr_data_o at their last values while rf_we_o=0.
REQ-011 SHALL register all outputs except ready_o.
REQ-012 SHALL meet this latency:
- Non-load accepted in cycle N: write in cycle N+1.
- Load with mem_valid_i in cycle M: write in cycle M+1.
REQ-013 SHALL go from WRITE to WAIT_MEM or WRITE when a request is accepted in that cycle, and to IDLE otherwise; back-to-back non-loads sustain one write per cycle.
REQ-014 SHALL detect misaligned loads when the load is accepted: LW with addr_lo!=0, or LH/LHU with addr_lo[0]=1.
- misalign_o pulses next cycle.
- No register is written; state goes to IDLE.
REQ-015 SHALL, on flush_i=1 in WAIT_MEM, return to IDLE next cycle with no write, ignoring any mem_valid_i in the same cycle.
REQ-016 SHALL, on flush_i=1 in WRITE, still complete that cycle's registered write and accept no new request.
REQ-017 SHALL ignore mem_valid_i in IDLE and WRITE.

Reset
REQ-018 SHALL, on rst=1, enter IDLE next edge and clear rf_we_o, rf_wr_addr_o, rf_wr_data_o, pending_o, pending_dest_o and misalign_o to 0.
REQ-019 SHALL let reset override every other input, including during WAIT_MEM and WRITE; an interrupted load or write is dropped.

Configuration
REQ-020 SHALL, with WB_SUBWORD_EN defined, implement all load types per REQ-006 and REQ-014.
REQ-021 SHALL, without WB_SUBWORD_EN, treat every load as LW: mem_data_i is written unchanged, load_type_i is ignored, and misalign_o fires only for addr_lo!=0.

Verification
REQ-022 SHALL cover: non-load, dest=5, result=0x12345678 accepted in cycle N -> rf_we_o=1, addr 5, data 0x12345678 in N+1 only.
REQ-023 SHALL cover: LB, addr_lo=3, mem_data=0x80FF0011 -> data 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU, addr_lo=2 -> 0x000080FF.
REQ-024 SHALL cover: non-load with dest=0, or with wb_en_i=0 -> rf_we_o stays 0 and ready_o returns to 1.
REQ-025 SHALL cover: load accepted, flush_i in WAIT_MEM together with mem_valid_i -> no write, pending_o=0 and state IDLE next cycle.
REQ-026 SHALL cover: LW with addr_lo=1 -> misalign_o pulse, no write; without WB_SUBWORD_EN, LB at addr_lo=0 with data 0x000000F0 -> data 0x000000F0.
REQ-027 SHALL cover: rst asserted in WAIT_MEM, then mem_valid_i -> all outputs 0 and no write.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results and loads into the register file.
// Define WB_SUBWORD_EN for LH/LHU/LB/LBU extraction; otherwise every load is LW.
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        wb_en_i,
  input  logic [4:0]  dest_i,
  input  logic [31:0] result_i,
  input  logic        is_load_i,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        flush_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_wr_addr_o,
  output logic [31:0] rf_wr_data_o,
  output logic        pending_o,
  output logic [4:0]  pending_dest_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  dest_q, dest_d;
  logic        wb_en_q, wb_en_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wr_addr_q, rf_wr_addr_d;
  logic [31:0] rf_wr_data_q, rf_wr_data_d;
  logic        pending_q, pending_d;
  logic [4:0]  pending_dest_q, pending_dest_d;
  logic        misalign_q, misalign_d;

  logic        accept;
  logic        mis_w;
  logic [31:0] load_w;

`ifdef WB_SUBWORD_EN
  logic [2:0]  type_q, type_d;
  logic [1:0]  lo_q, lo_d;
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    unique case (load_type_i)
      3'b001, 3'b010: mis_w = addr_lo_i[0];
      3'b011, 3'b100: mis_w = 1'b0;
      default:        mis_w = |addr_lo_i;
    endcase
  end

  always_comb begin
    unique case (lo_q)
      2'd0:    byte_w = mem_data_i[7:0];
      2'd1:    byte_w = mem_data_i[15:8];
      2'd2:    byte_w = mem_data_i[23:16];
      default: byte_w = mem_data_i[31:24];
    endcase
    half_w = lo_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    unique case (type_q)
      3'b001:  load_w = {{16{half_w[15]}}, half_w};
      3'b010:  load_w = {16'h0, half_w};
      3'b011:  load_w = {{24{byte_w[7]}}, byte_w};
      3'b100:  load_w = {24'h0, byte_w};
      default: load_w = mem_data_i;
    endcase
  end
`else
  logic unused_load_type;

  assign unused_load_type = ^load_type_i;
  assign mis_w  = |addr_lo_i;
  assign load_w = mem_data_i;
`endif

  assign ready_o = (state_q != WAIT_MEM);
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    wb_en_d      = wb_en_q;
    rf_we_d      = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    misalign_d   = 1'b0;
`ifdef WB_SUBWORD_EN
    type_d       = type_q;
    lo_d         = lo_q;
`endif
    unique case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept) begin
          if (is_load_i) begin
            if (mis_w) begin
              misalign_d = 1'b1;
            end else begin
              state_d = WAIT_MEM;
              dest_d  = dest_i;
              wb_en_d = wb_en_i;
`ifdef WB_SUBWORD_EN
              type_d  = load_type_i;
              lo_d    = addr_lo_i;
`endif
            end
          end else begin
            state_d = WRITE;
            if (wb_en_i && (dest_i != 5'd0)) begin
              rf_we_d      = 1'b1;
              rf_wr_addr_d = dest_i;
              rf_wr_data_d = result_i;
            end
          end
        end
      end
      WAIT_MEM: begin
        // flush wins over a same-cycle memory response
        if (flush_i) begin
          state_d = IDLE;
        end else if (mem_valid_i) begin
          state_d = WRITE;
          if (wb_en_q && (dest_q != 5'd0)) begin
            rf_we_d      = 1'b1;
            rf_wr_addr_d = dest_q;
            rf_wr_data_d = load_w;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d      = (state_d == WAIT_MEM);
    pending_dest_d = pending_d ? dest_d : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dest_q         <= 5'd0;
      wb_en_q        <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_wr_addr_q   <= 5'd0;
      rf_wr_data_q   <= 32'd0;
      pending_q      <= 1'b0;
      pending_dest_q <= 5'd0;
      misalign_q     <= 1'b0;
`ifdef WB_SUBWORD_EN
      type_q         <= 3'd0;
      lo_q           <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      dest_q         <= dest_d;
      wb_en_q        <= wb_en_d;
      rf_we_q        <= rf_we_d;
      rf_wr_addr_q   <= rf_wr_addr_d;
      rf_wr_data_q   <= rf_wr_data_d;
      pending_q      <= pending_d;
      pending_dest_q <= pending_dest_d;
      misalign_q     <= misalign_d;
`ifdef WB_SUBWORD_EN
      type_q         <= type_d;
      lo_q           <= lo_d;
`endif
    end
  end

  assign rf_we_o        = rf_we_q;
  assign rf_wr_addr_o   = rf_wr_addr_q;
  assign rf_wr_data_o   = rf_wr_data_q;
  assign pending_o      = pending_q;
  assign pending_dest_o = pending_dest_q;
  assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: table vectors, hand sequences, random traffic.
// Expected values come from a transaction-level model of the writeback rules.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst, valid_i, wb_en_i, is_load_i, flush_i, mem_valid_i;
  logic [4:0]  dest_i;
  logic [31:0] result_i, mem_data_i;
  logic [2:0]  load_type_i;
  logic [1:0]  addr_lo_i;
  logic        ready_o, rf_we_o, pending_o, misalign_o;
  logic [4:0]  rf_wr_addr_o, pending_dest_o;
  logic [31:0] rf_wr_data_o;

  writeback_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .wb_en_i(wb_en_i), .dest_i(dest_i), .result_i(result_i),
    .is_load_i(is_load_i), .load_type_i(load_type_i),
    .addr_lo_i(addr_lo_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .rf_we_o(rf_we_o), .rf_wr_addr_o(rf_wr_addr_o),
    .rf_wr_data_o(rf_wr_data_o), .pending_o(pending_o),
    .pending_dest_o(pending_dest_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: one outstanding load at most
  bit          m_out;
  logic [4:0]  m_dest;
  bit          m_wb;
  int          m_t, m_lo;
  bit          e_we, e_pend, e_mis;
  logic [4:0]  e_addr, e_pdest;
  logic [31:0] e_data;

  typedef struct {
    bit          is_load;
    bit          wb_en;
    logic [4:0]  dest;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [31:0] data;
    bit          exp_we;
    logic [31:0] exp_data;
    bit          exp_mis;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ext(int t, int lo, logic [31:0] w);
`ifdef WB_SUBWORD_EN
    int b, h;
    b = int'(w >> (8 * lo)) & 255;
    h = (lo >= 2) ? int'(w >> 16) : int'(w) & 65535;
    h = h & 65535;
    case (t)
      1: return (h >= 32768) ? h - 65536 : h;
      2: return h;
      3: return (b >= 128) ? b - 256 : b;
      4: return b;
      default: return w;
    endcase
`else
    return w;
`endif
  endfunction

  function automatic bit m_mis(int t, int lo);
`ifdef WB_SUBWORD_EN
    if (t == 1 || t == 2) return (lo % 2) == 1;
    if (t == 3 || t == 4) return 1'b0;
`endif
    return lo != 0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_out = 0; e_we = 0; e_addr = 0; e_data = 0; e_mis = 0;
    end else begin
      e_we = 0;
      e_mis = 0;
      if (m_out) begin
        if (flush_i) m_out = 0;
        else if (mem_valid_i) begin
          m_out = 0;
          if (m_wb && m_dest != 0) begin
            e_we = 1;
            e_addr = m_dest;
            e_data = m_ext(m_t, m_lo, mem_data_i);
          end
        end
      end else if (valid_i && !flush_i) begin
        if (is_load_i) begin
          if (m_mis(int'(load_type_i), int'(addr_lo_i))) e_mis = 1;
          else begin
            m_out = 1; m_dest = dest_i; m_wb = wb_en_i;
            m_t = int'(load_type_i); m_lo = int'(addr_lo_i);
          end
        end else if (wb_en_i && dest_i != 0) begin
          e_we = 1; e_addr = dest_i; e_data = result_i;
        end
      end
    end
    e_pend = m_out;
    e_pdest = m_out ? m_dest : 5'd0;
  endtask

  task automatic tick();
    chk("ready", {31'd0, ready_o}, {31'd0, !m_out});
    model_step();
    @(posedge clk);
    #1;
    chk("we", {31'd0, rf_we_o}, {31'd0, e_we});
    chk("addr", {27'd0, rf_wr_addr_o}, {27'd0, e_addr});
    chk("data", rf_wr_data_o, e_data);
    chk("pend", {31'd0, pending_o}, {31'd0, e_pend});
    chk("pdest", {27'd0, pending_dest_o}, {27'd0, e_pdest});
    chk("mis", {31'd0, misalign_o}, {31'd0, e_mis});
  endtask

  task automatic idle_inputs();
    valid_i = 0; wb_en_i = 0; is_load_i = 0; flush_i = 0;
    mem_valid_i = 0; dest_i = 0; result_i = 0; mem_data_i = 0;
    load_type_i = 0; addr_lo_i = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    valid_i = 1; wb_en_i = v.wb_en; dest_i = v.dest;
    is_load_i = v.is_load; load_type_i = v.lt; addr_lo_i = v.lo;
    result_i = v.is_load ? $urandom : v.data;
    tick();
    valid_i = 0;
    if (!v.is_load) begin
      chk("vec_we", {31'd0, rf_we_o}, {31'd0, v.exp_we});
      if (v.exp_we) chk("vec_data", rf_wr_data_o, v.exp_data);
    end else if (v.exp_mis) begin
      chk("vec_mis", {31'd0, misalign_o}, 32'd1);
      chk("vec_mis_we", {31'd0, rf_we_o}, 32'd0);
    end else begin
      chk("vec_pend", {31'd0, pending_o}, 32'd1);
      mem_valid_i = 1; mem_data_i = v.data;
      tick();
      mem_valid_i = 0;
      chk("vec_ld_we", {31'd0, rf_we_o}, {31'd0, v.exp_we});
      if (v.exp_we) chk("vec_ld_data", rf_wr_data_o, v.exp_data);
    end
    tick();
    chk("vec_idle_we", {31'd0, rf_we_o}, 32'd0);
    chk("vec_idle_mis", {31'd0, misalign_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vt.push_back('{0, 1, 5'd5, 3'd0, 2'd0, 32'h12345678, 1, 32'h12345678, 0});
    vt.push_back('{0, 1, 5'd0, 3'd0, 2'd0, 32'hDEADBEEF, 0, 32'h0, 0});
    vt.push_back('{0, 0, 5'd7, 3'd0, 2'd0, 32'hCAFEF00D, 0, 32'h0, 0});
    vt.push_back('{1, 1, 5'd9, 3'd0, 2'd0, 32'h80FF0011, 1, 32'h80FF0011, 0});
    vt.push_back('{1, 1, 5'd3, 3'd0, 2'd1, 32'h0, 0, 32'h0, 1});
`ifdef WB_SUBWORD_EN
    vt.push_back('{1, 1, 5'd4, 3'd3, 2'd3, 32'h80FF0011, 1, 32'hFFFFFF80, 0});
    vt.push_back('{1, 1, 5'd4, 3'd4, 2'd3, 32'h80FF0011, 1, 32'h00000080, 0});
    vt.push_back('{1, 1, 5'd6, 3'd2, 2'd2, 32'h80FF0011, 1, 32'h000080FF, 0});
    vt.push_back('{1, 1, 5'd6, 3'd1, 2'd2, 32'h80FF0011, 1, 32'hFFFF80FF, 0});
    vt.push_back('{1, 1, 5'd8, 3'd1, 2'd1, 32'h0, 0, 32'h0, 1});
    vt.push_back('{1, 1, 5'd8, 3'd3, 2'd1, 32'h00001200, 1, 32'h00000012, 0});
`else
    vt.push_back('{1, 1, 5'd4, 3'd3, 2'd0, 32'h000000F0, 1, 32'h000000F0, 0});
    vt.push_back('{1, 1, 5'd4, 3'd3, 2'd1, 32'h0, 0, 32'h0, 1});
    vt.push_back('{1, 1, 5'd6, 3'd2, 2'd0, 32'h80FF0011, 1, 32'h80FF0011, 0});
`endif
    vt.push_back('{1, 0, 5'd10, 3'd0, 2'd0, 32'h11111111, 0, 32'h0, 0});

    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    tick();
    rst = 0;
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_data", rf_wr_data_o, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);

    foreach (vt[i]) apply_vec(vt[i]);

    // load flushed in WAIT_MEM together with a memory response
    valid_i = 1; is_load_i = 1; wb_en_i = 1; dest_i = 5'd12;
    tick();
    valid_i = 0;
    chk("fl_pdest", {27'd0, pending_dest_o}, 32'd12);
    flush_i = 1; mem_valid_i = 1; mem_data_i = 32'h55AA55AA;
    tick();
    flush_i = 0; mem_valid_i = 0;
    chk("fl_we", {31'd0, rf_we_o}, 32'd0);
    chk("fl_pend", {31'd0, pending_o}, 32'd0);
    chk("fl_ready", {31'd0, ready_o}, 32'd1);

    // back-to-back non-loads, then flush while in WRITE
    is_load_i = 0; valid_i = 1; wb_en_i = 1;
    for (int k = 1; k <= 3; k++) begin
      dest_i = 5'(k + 20); result_i = 32'(k * 32'h01010101);
      tick();
      chk("b2b_we", {31'd0, rf_we_o}, 32'd1);
      chk("b2b_addr", {27'd0, rf_wr_addr_o}, 32'(k + 20));
    end
    flush_i = 1; dest_i = 5'd30;
    tick();
    flush_i = 0; valid_i = 0;
    chk("flw_we", {31'd0, rf_we_o}, 32'd0);
    chk("flw_hold", {27'd0, rf_wr_addr_o}, 32'd23);

    // reset during WAIT_MEM, then a stray memory response
    valid_i = 1; is_load_i = 1; wb_en_i = 1; dest_i = 5'd14;
    tick();
    valid_i = 0;
    rst = 1; mem_valid_i = 1; mem_data_i = 32'h77777777;
    tick();
    rst = 0;
    tick();
    mem_valid_i = 0;
    chk("rstw_we", {31'd0, rf_we_o}, 32'd0);
    chk("rstw_pend", {31'd0, pending_o}, 32'd0);
    chk("rstw_data", rf_wr_data_o, 32'd0);

    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(99) < 2);
      flush_i     = ($urandom_range(99) < 10);
      mem_valid_i = ($urandom_range(99) < 40);
      valid_i     = ($urandom_range(99) < 65);
      is_load_i   = $urandom_range(1);
      wb_en_i     = ($urandom_range(99) < 85);
      dest_i      = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      load_type_i = 3'($urandom);
      addr_lo_i   = 2'($urandom);
      result_i    = $urandom;
      mem_data_i  = $urandom;
      tick();
    end
    idle_inputs();
    rst = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
